// File: rtl/reg_arb_pkg.sv
// Shared definitions for the host/PID register-file arbiter: FSM states,
// requester ids, default geometry and the tie-break rule.
package reg_arb_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_HOST = 1'b0,
        GNT_PID  = 1'b1
    } gnt_t;

    // On a tie the side that was not granted last wins; a lone request always wins.
    function automatic gnt_t pick_winner(input logic h_req, input logic p_req,
                                         input gnt_t last_grant);
        gnt_t w;
        if (h_req && p_req) begin
            if (last_grant == GNT_PID) w = GNT_HOST;
            else                       w = GNT_PID;
        end else if (p_req) begin
            w = GNT_PID;
        end else begin
            w = GNT_HOST;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Single-port register file: synchronous write, registered read, and an
// asynchronous clear of every entry.
module reg_file
    import reg_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: clearing the whole array on reset forces flops rather than a RAM macro; the clear is required here.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Arbitrates host read/write and PID read-only accesses onto one shared
// register file; one access in flight, IDLE -> ACCESS -> RESP.
module reg_arbiter
    import reg_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          h_req_i,
    input  logic          h_we_i,
    input  logic [AW-1:0] h_addr_i,
    input  logic [DW-1:0] h_wdata_i,
    output logic          h_ack_o,
    output logic [DW-1:0] h_rdata_o,
    input  logic          p_req_i,
    input  logic [AW-1:0] p_addr_i,
    output logic          p_ack_o,
    output logic [DW-1:0] p_rdata_o,
    output logic          busy_o
);

    arb_state_t    state_q, state_d;
    gnt_t          gnt_q, last_grant_q, winner;
    logic          accept;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rf_rdata;
    logic [DW-1:0] h_rdata_q, p_rdata_q;
    logic          rf_en;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        winner  = pick_winner(h_req_i, p_req_i, last_grant_q);
        unique case (state_q)
            IDLE: begin
                if (h_req_i || p_req_i) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_o  = (state_q != IDLE);
        rf_en   = (state_q == ACCESS);
        h_ack_o = (state_q == RESP) && (gnt_q == GNT_HOST);
        p_ack_o = (state_q == RESP) && (gnt_q == GNT_PID);
        // Read data is live from the file only in the ack cycle; otherwise the held copy.
        h_rdata_o = (h_ack_o && !we_q) ? rf_rdata : h_rdata_q;
        p_rdata_o = p_ack_o ? rf_rdata : p_rdata_q;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_HOST;
            last_grant_q <= GNT_PID;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            h_rdata_q    <= '0;
            p_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_q        <= winner;
                last_grant_q <= winner;
                // The PID side is read-only, so its accesses never carry a write.
                we_q         <= (winner == GNT_HOST) && h_we_i;
                addr_q       <= (winner == GNT_HOST) ? h_addr_i : p_addr_i;
                wdata_q      <= h_wdata_i;
            end
            if (h_ack_o && !we_q) begin
                h_rdata_q <= rf_rdata;
            end
            if (p_ack_o) begin
                p_rdata_q <= rf_rdata;
            end
        end
    end

    reg_file #(
        .AW(AW),
        .DW(DW)
    ) u_reg_file (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (rf_en),
        .we     (we_q),
        .addr   (addr_q),
        .wdata  (wdata_q),
        .rdata  (rf_rdata)
    );

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: a transaction-level model indexed by
// clock-edge number plus directed scenarios with literal expectations.
module tb_reg_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk_in;
    logic          reset;
    logic          h_req_i, h_we_i, p_req_i;
    logic [AW-1:0] h_addr_i, p_addr_i;
    logic [DW-1:0] h_wdata_i;
    logic          h_ack_o, p_ack_o, busy_o;
    logic [DW-1:0] h_rdata_o, p_rdata_o;

    int n_tests = 0;
    int n_fail  = 0;
    int h_ack_cnt = 0;

    reg_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .h_req_i   (h_req_i),
        .h_we_i    (h_we_i),
        .h_addr_i  (h_addr_i),
        .h_wdata_i (h_wdata_i),
        .h_ack_o   (h_ack_o),
        .h_rdata_o (h_rdata_o),
        .p_req_i   (p_req_i),
        .p_addr_i  (p_addr_i),
        .p_ack_o   (p_ack_o),
        .p_rdata_o (p_rdata_o),
        .busy_o    (busy_o)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: an access accepted at edge A is performed at edge A+1, acked in the
    // cycle after A+1, and the arbiter is free to accept again at edge A+3.
    logic [DW-1:0] mem_m [16];
    int            edge_n   = 0;
    int            acc_edge = 0;
    bit            have_acc = 1'b0;
    bit            m_win_pid = 1'b0;
    bit            m_last_pid = 1'b1;
    bit            m_we = 1'b0;
    int            m_addr = 0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_h_rd = '0;
    logic [DW-1:0] m_p_rd = '0;
    bit            e_busy, e_ack;

    initial forever begin
        @(posedge clk_in or negedge reset);
        if (!reset) begin
            foreach (mem_m[i]) mem_m[i] = '0;
            have_acc   = 1'b0;
            m_last_pid = 1'b1;
            m_h_rd     = '0;
            m_p_rd     = '0;
        end else begin
            edge_n++;
            if (have_acc && edge_n == acc_edge + 1) begin
                if (m_we)           mem_m[m_addr] = m_wdata;
                else if (m_win_pid) m_p_rd = mem_m[m_addr];
                else                m_h_rd = mem_m[m_addr];
            end
            if ((!have_acc || edge_n >= acc_edge + 3) && (h_req_i || p_req_i)) begin
                if (h_req_i && p_req_i) m_win_pid = !m_last_pid;
                else                    m_win_pid = p_req_i;
                m_last_pid = m_win_pid;
                m_we       = !m_win_pid && h_we_i;
                m_addr     = m_win_pid ? int'(p_addr_i) : int'(h_addr_i);
                m_wdata    = h_wdata_i;
                have_acc   = 1'b1;
                acc_edge   = edge_n;
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        e_busy = have_acc && (edge_n == acc_edge || edge_n == acc_edge + 1);
        e_ack  = have_acc && (edge_n == acc_edge + 1);
        check("busy_o",    busy_o,    e_busy);
        check("h_ack_o",   h_ack_o,   e_ack && !m_win_pid);
        check("p_ack_o",   p_ack_o,   e_ack && m_win_pid);
        check("h_rdata_o", h_rdata_o, m_h_rd);
        check("p_rdata_o", p_rdata_o, m_p_rd);
        if (h_ack_o) h_ack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // Raises a host request in an IDLE cycle; lat counts negedges until h_ack_o.
    task automatic host_access(input bit we, input int addr, input logic [DW-1:0] wd,
                               output int lat, output logic [DW-1:0] rd);
        h_req_i = 1'b1; h_we_i = we; h_addr_i = addr[AW-1:0]; h_wdata_i = wd;
        lat = -1; rd = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (h_ack_o) begin
                lat = c; rd = h_rdata_o;
                break;
            end
        end
        #1;
        h_req_i = 1'b0; h_we_i = 1'b0;
        check("h_ack_seen", lat > 0, 1'b1);
        tick();
    endtask

    task automatic pid_access(input int addr, output int lat, output logic [DW-1:0] rd);
        p_req_i = 1'b1; p_addr_i = addr[AW-1:0];
        lat = -1; rd = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (p_ack_o) begin
                lat = c; rd = p_rdata_o;
                break;
            end
        end
        #1;
        p_req_i = 1'b0;
        check("p_ack_seen", lat > 0, 1'b1);
        tick();
    endtask

    initial begin
        int lat, lat_h, lat_p, cnt0;
        logic [DW-1:0] rd, rd_h, rd_p;
        bit got;

        reset = 1'b0;
        h_req_i = 1'b0; h_we_i = 1'b0; h_addr_i = '0; h_wdata_i = '0;
        p_req_i = 1'b0; p_addr_i = '0;
        repeat (2) tick();
        check("rst_busy",    busy_o,    1'b0);
        check("rst_h_ack",   h_ack_o,   1'b0);
        check("rst_p_ack",   p_ack_o,   1'b0);
        check("rst_h_rdata", h_rdata_o, 16'h0000);
        check("rst_p_rdata", p_rdata_o, 16'h0000);
        reset = 1'b1;

        // Write then read back addr 3.
        host_access(1'b1, 3, 16'h1234, lat, rd);
        check("wr3_lat", lat, 2);
        host_access(1'b0, 3, '0, lat, rd);
        check("rd3_lat", lat, 2);
        check("rd3_data", rd, 16'h1234);

        // Request dropped one cycle after acceptance still completes once.
        cnt0 = h_ack_cnt;
        h_req_i = 1'b1; h_we_i = 1'b0; h_addr_i = 4'd3;
        tick();
        check("drop_busy", busy_o, 1'b1);
        h_req_i = 1'b0;
        repeat (5) tick();
        check("drop_ack_count", h_ack_cnt - cnt0, 1);
        check("drop_rdata", h_rdata_o, 16'h1234);

        // Ties after reset: host first, then PID; after a host-only access the PID wins.
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        fork
            host_access(1'b0, 3, '0, lat_h, rd_h);
            pid_access(7, lat_p, rd_p);
        join
        check("tie1_host_lat", lat_h, 2);
        check("tie1_pid_lat",  lat_p, 5);
        check("tie1_host_rd",  rd_h, 16'h0000);
        host_access(1'b1, 7, 16'hA5A5, lat, rd);
        check("wr7_lat", lat, 2);
        fork
            host_access(1'b0, 7, '0, lat_h, rd_h);
            pid_access(7, lat_p, rd_p);
        join
        check("tie2_pid_lat",  lat_p, 2);
        check("tie2_host_lat", lat_h, 5);
        check("tie2_pid_rd",   rd_p, 16'hA5A5);
        check("tie2_host_rd",  rd_h, 16'hA5A5);

        // Continuous PID reads of addr 0 with a host write interleaved.
        p_req_i = 1'b1; p_addr_i = 4'd0;
        repeat (4) tick();
        host_access(1'b1, 0, 16'hBEEF, lat, rd);
        check("interleave_lat", (lat >= 2) && (lat <= 5), 1'b1);
        got = 1'b0; rd = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_in);
            if (p_ack_o) begin
                got = 1'b1; rd = p_rdata_o;
                break;
            end
        end
        #1;
        p_req_i = 1'b0;
        check("pid_after_wr_seen", got, 1'b1);
        check("pid_after_wr_data", rd, 16'hBEEF);
        tick();

        // Reset during the ACCESS cycle of a write aborts it.
        cnt0 = h_ack_cnt;
        h_req_i = 1'b1; h_we_i = 1'b1; h_addr_i = 4'd5; h_wdata_i = 16'h00FF;
        tick();
        check("abort_busy", busy_o, 1'b1);
        reset = 1'b0; h_req_i = 1'b0; h_we_i = 1'b0;
        #1;
        check("abort_async_busy", busy_o, 1'b0);
        check("abort_async_rdata", h_rdata_o, 16'h0000);
        repeat (3) tick();
        check("abort_no_ack", h_ack_cnt - cnt0, 0);
        reset = 1'b1;
        host_access(1'b0, 5, '0, lat, rd);
        check("post_rst_lat", lat, 2);
        check("post_rst_rd5", rd, 16'h0000);

        // Top address boundary.
        host_access(1'b1, 15, 16'hFFFF, lat, rd);
        check("wr15_lat", lat, 2);
        host_access(1'b0, 15, '0, lat, rd);
        check("rd15_data", rd, 16'hFFFF);
        host_access(1'b0, 0, '0, lat, rd);
        check("rd0_unchanged", rd, 16'h0000);
        pid_access(15, lat, rd);
        check("pid_rd15", rd, 16'hFFFF);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 SHALL have parameter AW, default 4: register address width (16 entries).
REQ-002 SHALL have parameter DW, default 16: register data width.
REQ-003 SHALL have port clk_in, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port h_req_i, input, 1: host (UART side) request, level, held until h_ack_o.
REQ-006 SHALL have port h_we_i, input, 1: host request type, 1 = write, 0 = read.
REQ-007 SHALL have port h_addr_i, input, AW: host register address.
REQ-008 SHALL have port h_wdata_i, input, DW: host write data.
REQ-009 SHALL have port h_ack_o, output, 1: one-cycle host completion pulse.
REQ-010 SHALL have port h_rdata_o, output, DW: host read data, valid while h_ack_o=1.
REQ-011 SHALL have port p_req_i, input, 1: PID core read request, level, held until p_ack_o.
REQ-012 SHALL have port p_addr_i, input, AW: PID core read address.
REQ-013 SHALL have port p_ack_o, output, 1: one-cycle PID completion pulse.
REQ-014 SHALL have port p_rdata_o, output, DW: PID read data, valid while p_ack_o=1.
REQ-015 SHALL have port busy_o, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL serialise all accesses to one shared AW x DW register file; one access in flight at a time.
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, each of ACCESS and RESP lasting exactly one cycle.
REQ-018 SHALL, in IDLE with any request sampled high, latch winner id, we, addr, wdata and enter ACCESS next cycle.
REQ-019 SHALL, in ACCESS, perform the write (host we=1) or register the read data; read data SHALL NOT be combinational from inputs.
REQ-020 SHALL, in RESP, pulse exactly the winner's ack for one cycle with rdata driven; the loser's ack SHALL stay 0.
REQ-021 SHALL give request-to-ack latency of 2 cycles (request seen in IDLE at cycle N, ack at cycle N+2).
REQ-022 SHALL, on simultaneous h_req_i and p_req_i in IDLE, grant the requester not granted last (round-robin via last_grant bit).
REQ-023 SHALL treat a PID request as read-only; p side never writes.
REQ-024 SHALL complete an accepted access and pulse ack even if its request drops before RESP.
REQ-025 SHALL not re-grant a requester in the IDLE cycle that follows its own RESP unless the other side is idle (back-to-back from one side allowed, max 1 in 3 cycles).
REQ-026 SHALL, for a host read of an address written in the immediately preceding access, return the newly written value.
REQ-027 SHALL hold h_rdata_o/p_rdata_o at last value outside ack cycles.
REQ-028 SHALL ignore address bits beyond AW (none exist); every address 0..2^AW-1 is read/write.

Reset
REQ-029 SHALL, on reset low, immediately force FSM to IDLE, acks 0, busy_o 0, rdata outputs 0, last_grant = PID (so host wins first tie).
REQ-030 SHALL clear all register file entries to 0 on reset.
REQ-031 SHALL abort an in-flight access on reset mid-operation: no ack, no partial write after release.
REQ-032 SHALL accept a new request in the first cycle reset is high.

Structure
REQ-033 SHALL place FSM state encoding (IDLE, ACCESS, RESP), requester ids (GNT_HOST, GNT_PID) and default AW/DW in shared package reg_arb_pkg.
REQ-034 SHALL instantiate one sub-module reg_file (synchronous write, registered read, async active-low clear).

Verification
REQ-035 SHALL test host write 0x1234 to addr 3, then host read addr 3 -> h_ack_o at cycle +2 each, h_rdata_o = 0x1234.
REQ-036 SHALL test simultaneous h_req_i/p_req_i after reset -> host served first, PID ack 3 cycles later; next tie -> PID first.
REQ-037 SHALL test PID continuous reads of addr 0 with host write 0xBEEF to addr 0 -> writes interleave, subsequent p_rdata_o = 0xBEEF.
REQ-038 SHALL test reset asserted during ACCESS of host write 0x00FF to addr 5 -> no h_ack_o; read addr 5 after release returns 0x0000.
REQ-039 SHALL test h_req_i dropped one cycle after acceptance -> h_ack_o still pulses exactly once.
REQ-040 SHALL test write then read of addr 15 (wrap boundary) with 0xFFFF -> returns 0xFFFF, addr 0 unchanged.
